// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the SRAM slave FSM state type.
//   HTRANS_*  : transfer type encodings
//   HSIZE_*   : transfer size encodings (log2 of byte count)
//   HRESP_*   : slave response encodings
//   sram_slv_st_t : data-phase state of ahb3lite_sram_slave
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } sram_slv_st_t;

endpackage

// File: rtl/ahb_sram_bytewr.sv
// Depth x DataWidth memory array with per-byte write enables and an asynchronous read port.
// Read and write share one index (single-port).
//   clk_i   : write clock
//   we_i    : per-byte write enable, bit i covers wdata_i[8*i +: 8]
//   idx_i   : word index for both read and write
//   wdata_i : write data
//   rdata_o : combinational read data at idx_i
module ahb_sram_bytewr #(
    parameter int unsigned Depth     = 2048,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxWidth  = 11,
    parameter string       InitFile  = ""
) (
    input  logic                   clk_i,
    input  logic [DataWidth/8-1:0] we_i,
    input  logic [IdxWidth-1:0]    idx_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic [DataWidth-1:0]   rdata_o
);

    localparam int unsigned NumBytes = DataWidth / 8;

    logic [DataWidth-1:0] mem_q [Depth];

    // Memory is intentionally not reset; only enabled lanes are written.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NumBytes; i++) begin
            if (we_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite single-port SRAM slave with byte-lane writes, programmable wait states and a
// two-cycle ERROR response for illegal transfers (oversize, misaligned, out of range).
//   HCLK/HRESETn : clock, asynchronous active-low reset
//   HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY : address phase inputs
//   HWDATA       : write data (data phase)
//   HBURST, HPROT, HMASTLOCK : accepted but ignored
//   HRDATA, HREADYOUT, HRESP : data phase outputs
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int unsigned MEM_DEPTH      = 2048,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned WAIT_STATES    = 0,
    parameter string       INIT_FILE      = ""
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
    input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [2:0]                HBURST,
    input  logic [3:0]                HPROT,
    input  logic [1:0]                HTRANS,
    input  logic                      HMASTLOCK,
    input  logic                      HREADY,
    output logic [AHB_DATA_WIDTH-1:0] HRDATA,
    output logic                      HREADYOUT,
    output logic                      HRESP
);

    localparam int unsigned NB  = AHB_DATA_WIDTH / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned LAW = OFF + IW;
    localparam logic [3:0]  WS  = 4'(WAIT_STATES);

    sram_slv_st_t        state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [LAW-1:0]      addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;

    logic                accept, illegal, misalign;
    logic                ready, resp, commit, take_new;
    logic [IW-1:0]       idx_a;
    logic [31:0]         lane_lo, lane_cnt;
    logic [NB-1:0]       be;
    logic [AHB_DATA_WIDTH-1:0] rdata, mem_rdata;

    logic unused_bus;
    assign unused_bus = ^{HBURST, HPROT, HMASTLOCK, HADDR, HTRANS[0]};

    assign accept = HSEL & HREADY & HTRANS[1];
    assign idx_a  = HADDR[LAW-1:OFF];

    // Legality is judged on the address phase so the error path never touches memory.
    always_comb begin
        misalign = 1'b0;
        for (int unsigned b = 0; b < OFF; b++) begin
            if ((b < 32'(HSIZE)) && HADDR[b]) misalign = 1'b1;
        end
        illegal = (32'(HSIZE) > OFF) || misalign || (32'(idx_a) >= MEM_DEPTH);
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        ready    = 1'b1;
        resp     = HRESP_OKAY;
        rdata    = '0;
        commit   = 1'b0;
        take_new = 1'b0;

        unique case (state_q)
            S_IDLE: take_new = 1'b1;
            S_DATA: begin
                ready = (wcnt_q == WS);
                if (!write_q) rdata = mem_rdata;
                if (!ready) begin
                    wcnt_d = wcnt_q + 4'd1;
                end else begin
                    commit   = write_q;
                    take_new = 1'b1;
                end
            end
            S_ERR1: begin
                ready   = 1'b0;
                resp    = HRESP_ERROR;
                state_d = S_ERR2;
            end
            S_ERR2: begin
                resp     = HRESP_ERROR;
                take_new = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (take_new) begin
            if (accept) begin
                addr_d  = HADDR[LAW-1:0];
                size_d  = HSIZE;
                write_d = HWRITE;
                wcnt_d  = '0;
                state_d = illegal ? S_ERR1 : S_DATA;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Little-endian lanes: 2**size_q bytes starting at the in-word byte offset.
    assign lane_lo  = 32'(addr_q[OFF-1:0]);
    assign lane_cnt = 32'd1 << size_q;

    always_comb begin
        be = '0;
        if (commit) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if ((i >= lane_lo) && (i < lane_lo + lane_cnt)) be[i] = 1'b1;
            end
        end
    end

    ahb_sram_bytewr #(
        .Depth     (MEM_DEPTH),
        .DataWidth (AHB_DATA_WIDTH),
        .IdxWidth  (IW),
        .InitFile  (INIT_FILE)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (be),
        .idx_i   (addr_q[LAW-1:OFF]),
        .wdata_i (HWDATA),
        .rdata_o (mem_rdata)
    );

    assign HRDATA    = rdata;
    assign HREADYOUT = ready;
    assign HRESP     = resp;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hready_lo;
    logic [1:0]  sel_inst;

    logic [31:0] rd0, rd2, rd3;
    logic        ro0, ro2, ro3, rs0, rs2, rs3;
    logic        rdy_sel, resp_sel, hready_bus;
    logic [31:0] rdata_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rdy_sel    = (sel_inst == 2'd0) ? ro0 : (sel_inst == 2'd1) ? ro2 : ro3;
    assign resp_sel   = (sel_inst == 2'd0) ? rs0 : (sel_inst == 2'd1) ? rs2 : rs3;
    assign rdata_sel  = (sel_inst == 2'd0) ? rd0 : (sel_inst == 2'd1) ? rd2 : rd3;
    assign hready_bus = rdy_sel & ~hready_lo;

    ahb3lite_sram_slave #(.MEM_DEPTH(2048), .AHB_DATA_WIDTH(32), .AHB_ADDR_WIDTH(32),
                          .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && sel_inst == 2'd0), .HADDR(haddr),
        .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready_bus), .HRDATA(rd0),
        .HREADYOUT(ro0), .HRESP(rs0));

    ahb3lite_sram_slave #(.MEM_DEPTH(48), .AHB_DATA_WIDTH(32), .AHB_ADDR_WIDTH(32),
                          .WAIT_STATES(2), .INIT_FILE("")) u_ws2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && sel_inst == 2'd1), .HADDR(haddr),
        .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready_bus), .HRDATA(rd2),
        .HREADYOUT(ro2), .HRESP(rs2));

    ahb3lite_sram_slave #(.MEM_DEPTH(64), .AHB_DATA_WIDTH(32), .AHB_ADDR_WIDTH(32),
                          .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && sel_inst == 2'd2), .HADDR(haddr),
        .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready_bus), .HRDATA(rd3),
        .HREADYOUT(ro3), .HRESP(rs3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    function automatic int exp_ws();
        return (sel_inst == 2'd0) ? 0 : (sel_inst == 2'd1) ? 2 : 3;
    endfunction

    // Single non-pipelined transfer; counts wait cycles and checks data on completion.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int n;
        hsel = 1'b1; haddr = a; hwrite = w; hsize = s; htrans = HTRANS_NONSEQ;
        to_pos();
        htrans = HTRANS_IDLE; hwdata = wd;
        n = 0;
        to_neg();
        while (rdy_sel !== 1'b1 && n < 20) begin
            to_pos();
            to_neg();
            n++;
        end
        chk({tag, "/waits"}, 64'(n), 64'(exp_ws()));
        chk({tag, "/resp"}, 64'(resp_sel), 64'(HRESP_OKAY));
        if (!w) chk({tag, "/rdata"}, 64'(rdata_sel), 64'(exp_rd));
        to_pos();
    endtask

    task automatic err_xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                            input string tag);
        hsel = 1'b1; haddr = a; hwrite = w; hsize = s; htrans = HTRANS_NONSEQ;
        to_pos();
        htrans = HTRANS_IDLE; hwdata = 32'hFFFF_FFFF;
        to_neg();
        chk({tag, "/e1 ready"}, 64'(rdy_sel), 64'd0);
        chk({tag, "/e1 resp"}, 64'(resp_sel), 64'(HRESP_ERROR));
        to_pos();
        to_neg();
        chk({tag, "/e2 ready"}, 64'(rdy_sel), 64'd1);
        chk({tag, "/e2 resp"}, 64'(resp_sel), 64'(HRESP_ERROR));
        to_pos();
        to_neg();
        chk({tag, "/after resp"}, 64'(resp_sel), 64'(HRESP_OKAY));
        to_pos();
    endtask

    initial begin
        rst_n = 1'b0; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
        hsize = HSIZE_WORD; htrans = HTRANS_IDLE; hready_lo = 1'b0; sel_inst = 2'd0;

        // Reset state
        to_pos();
        to_pos();
        to_neg();
        chk("rst ws0 ready", 64'(ro0), 64'd1);
        chk("rst ws0 resp", 64'(rs0), 64'd0);
        chk("rst ws0 rdata", 64'(rd0), 64'd0);
        chk("rst ws3 ready", 64'(ro3), 64'd1);
        chk("rst ws3 rdata", 64'(rd3), 64'd0);
        to_pos();
        rst_n = 1'b1;
        to_pos();

        // 1: word write then read, zero wait
        xfer(32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 32'h0, "t1 wr");
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'hDEAD_BEEF, "t1 rd");

        // 2: byte and halfword lanes
        xfer(32'h10, 1'b1, HSIZE_WORD, 32'h1122_3344, 32'h0, "t2 wr word");
        xfer(32'h11, 1'b1, HSIZE_BYTE, 32'h5A5A_AA5A, 32'h0, "t2 wr byte");
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'h1122_AA44, "t2 rd byte");
        xfer(32'h12, 1'b1, HSIZE_HALF, 32'h5566_7788, 32'h0, "t2 wr half");
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'h5566_AA44, "t2 rd half");
        xfer(32'h13, 1'b0, HSIZE_BYTE, 32'h0, 32'h5566_AA44, "t2 rd byte full word");

        // 4: misaligned word and oversize dword, memory untouched
        err_xfer(32'h13, 1'b1, HSIZE_WORD, "t4 misalign");
        err_xfer(32'h10, 1'b1, HSIZE_DWORD, "t4 dword");
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'h5566_AA44, "t4 rd intact");

        // 5: pipelined NONSEQ write then SEQ read of the same address
        hsel = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = HSIZE_WORD;
        htrans = HTRANS_NONSEQ;
        to_pos();
        hwdata = 32'hCAFE_F00D; htrans = HTRANS_SEQ; hwrite = 1'b0;
        to_neg();
        chk("t5 wr ready", 64'(rdy_sel), 64'd1);
        to_pos();
        htrans = HTRANS_IDLE;
        to_neg();
        chk("t5 rd ready", 64'(rdy_sel), 64'd1);
        chk("t5 rd data", 64'(rdata_sel), 64'hCAFE_F00D);
        to_pos();

        // 5: BUSY beat is a no-access zero-wait OKAY
        haddr = 32'h20; hwrite = 1'b1; htrans = HTRANS_BUSY;
        to_pos();
        htrans = HTRANS_IDLE; hwdata = 32'h0;
        to_neg();
        chk("t5 busy ready", 64'(rdy_sel), 64'd1);
        chk("t5 busy resp", 64'(resp_sel), 64'd0);
        chk("t5 busy rdata", 64'(rdata_sel), 64'd0);
        to_pos();

        // HREADY low from another slave: address phase must be ignored
        hready_lo = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h20;
        to_pos();
        hready_lo = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h0;
        to_pos();
        xfer(32'h20, 1'b0, HSIZE_WORD, 32'h0, 32'hCAFE_F00D, "t5 rd intact");

        // 3: two wait states, last legal index of a 48-deep instance
        sel_inst = 2'd1;
        xfer(32'hBC, 1'b1, HSIZE_WORD, 32'h1234_5678, 32'h0, "t3 wr");
        xfer(32'hBC, 1'b0, HSIZE_WORD, 32'h0, 32'h1234_5678, "t3 rd");
        err_xfer(32'hC0, 1'b0, HSIZE_WORD, "t3 out of range");

        // 6: reset in the middle of a three-wait write
        sel_inst = 2'd2;
        xfer(32'h4, 1'b1, HSIZE_WORD, 32'hA5A5_A5A5, 32'h0, "t6 pre wr");
        hsel = 1'b1; haddr = 32'h4; hwrite = 1'b1; hsize = HSIZE_WORD;
        htrans = HTRANS_NONSEQ;
        to_pos();
        htrans = HTRANS_IDLE; hwdata = 32'h0F0F_0F0F;
        to_pos();
        to_neg();
        chk("t6 waiting ready", 64'(rdy_sel), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t6 rst ready", 64'(rdy_sel), 64'd1);
        chk("t6 rst resp", 64'(resp_sel), 64'd0);
        chk("t6 rst rdata", 64'(rdata_sel), 64'd0);
        to_pos();
        to_pos();
        rst_n = 1'b1;
        to_pos();
        xfer(32'h4, 1'b0, HSIZE_WORD, 32'h0, 32'hA5A5_A5A5, "t6 rd intact");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
